// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, its upstream FIFO and the downstream consumer.
// master = fifo_reader side, slave = the surrounding environment.
interface fifo_reader_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              en;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_read;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  words_read;
    logic              busy;

    modport master (
        input  en, fifo_empty, fifo_data_out, out_ready,
        output fifo_read, out_valid, out_data, words_read, busy
    );

    modport slave (
        output en, fifo_empty, fifo_data_out, out_ready,
        input  fifo_read, out_valid, out_data, words_read, busy
    );
endinterface

// File: rtl/fifo_reader.sv
// Reads words from a FIFO with one-cycle read latency into a 2-entry skid buffer
// and presents them on a valid/ready output, counting delivered words.
module fifo_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    fifo_reader_if.master bus
);

    logic [1:0]        occ;
    logic              pending;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              pop;
    logic [2:0]        fill_after_pop;

    // occ + pending <= 2 always holds, so this never underflows
    assign pop            = (occ != 2'd0) && bus.out_ready;
    assign fill_after_pop = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};

    assign bus.fifo_read  = !rst && bus.en && !bus.fifo_empty && (fill_after_pop < 3'd2);
    assign bus.out_valid  = (occ != 2'd0);
    assign bus.out_data   = head_q;
    assign bus.words_read = cnt_q;
    assign bus.busy       = (occ != 2'd0) || pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ     <= 2'd0;
            pending <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pending <= bus.fifo_read;
            unique case ({pending, pop})
                2'b10: begin
                    if (occ == 2'd0) head_q <= bus.fifo_data_out;
                    else             tail_q <= bus.fifo_data_out;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: the incoming word lands behind whatever stays
                    if (occ == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= bus.fifo_data_out;
                    end else begin
                        head_q <= bus.fifo_data_out;
                    end
                end
                default: ;
            endcase
            if (pop && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized self-checking bench for fifo_reader against a queue-based reference model.
module tb_fifo_reader;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int MAXW   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] up_q[$];
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] got_q[$];
    bit                mpend;
    logic [DATA_W-1:0] mpend_data;
    int                mwords;
    bit                captured;

    logic              obs_read, obs_valid, obs_busy;
    logic [DATA_W-1:0] obs_data;
    logic [CNT_W-1:0]  obs_words;
    logic              exp_read, exp_valid, exp_busy, exp_pop;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  exp_words;
    bit                data_care;

    int cyc = 0;
    int rd_cnt, first_read, last_read, first_xfer, last_xfer;

    task automatic tick();
        logic [DATA_W-1:0] w;
        @(negedge clk);
        cyc++;
        obs_read  = bus.fifo_read;
        obs_valid = bus.out_valid;
        obs_data  = bus.out_data;
        obs_busy  = bus.busy;
        obs_words = bus.words_read;
        exp_valid = (mq.size() != 0);
        exp_pop   = exp_valid && bus.out_ready;
        exp_read  = !rst && bus.en && !bus.fifo_empty &&
                    ((int'(mq.size()) + int'(mpend) - int'(exp_pop)) < 2);
        exp_busy  = exp_valid || mpend;
        exp_words = mwords[CNT_W-1:0];
        data_care = exp_valid || !captured;
        exp_data  = exp_valid ? mq[0] : '0;
        if (obs_read === 1'b1) begin
            rd_cnt++;
            if (first_read < 0) first_read = cyc;
            last_read = cyc;
        end
        if (obs_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got_q.push_back(obs_data);
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            mpend    = 1'b0;
            mwords   = 0;
            captured = 1'b0;
        end else begin
            if (exp_pop) begin
                void'(mq.pop_front());
                if (mwords < MAXW) mwords++;
            end
            if (mpend) begin
                mq.push_back(mpend_data);
                captured = 1'b1;
            end
            mpend = exp_read;
        end
        if (obs_read === 1'b1) begin
            w = (up_q.size() != 0) ? up_q.pop_front() : DATA_W'($urandom);
            mpend_data = w;
            bus.fifo_data_out = w;
        end else begin
            bus.fifo_data_out = DATA_W'($urandom);
        end
        bus.fifo_empty = (up_q.size() == 0);
    endtask

    task automatic clear_stats();
        got_q.delete();
        rd_cnt = 0; first_read = -1; last_read = -1; first_xfer = -1; last_xfer = -1;
    endtask

    task automatic preload(input int n, input int base, input bit rnd);
        up_q.delete();
        for (int i = 0; i < n; i++) up_q.push_back(rnd ? DATA_W'($urandom) : DATA_W'(base + i));
        bus.fifo_empty = (up_q.size() == 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        preload(8, 'h10, 1'b0);
        bus.en = 1'b1; bus.out_ready = 1'b1; rst = 1'b1;
        repeat (2) begin
            tick();
            total++;
            if (obs_read !== 1'b0) begin bad++; $display("FAIL reset_read cyc=%0d got=%b exp=0", cyc, obs_read); end
        end
        rst = 1'b0; bus.en = 1'b0;
        tick();
        total += 3;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", obs_valid); end
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", obs_busy); end
        if (obs_words !== '0) begin bad++; $display("FAIL reset_words got=%0d exp=0", obs_words); end
        total++;
        if (obs_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=00", obs_data); end
    endtask

    task automatic test_stream();
        clear_stats();
        bus.en = 1'b1; bus.out_ready = 1'b1;
        repeat (14) begin
            tick();
            total += 4;
            if (obs_read !== exp_read) begin bad++; $display("FAIL stream_read cyc=%0d got=%b exp=%b", cyc, obs_read, exp_read); end
            if (obs_valid !== exp_valid) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
            if (obs_busy !== exp_busy) begin bad++; $display("FAIL stream_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, exp_busy); end
            if (obs_words !== exp_words) begin bad++; $display("FAIL stream_words cyc=%0d got=%0d exp=%0d", cyc, obs_words, exp_words); end
            if (data_care) begin
                total++;
                if (obs_data !== exp_data) begin bad++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, obs_data, exp_data); end
            end
        end
        total += 5;
        if (rd_cnt != 8) begin bad++; $display("FAIL stream_reads got=%0d exp=8", rd_cnt); end
        if (last_read - first_read != 7) begin bad++; $display("FAIL stream_read_span got=%0d exp=7", last_read - first_read); end
        if (first_xfer - first_read != 2) begin bad++; $display("FAIL stream_latency got=%0d exp=2", first_xfer - first_read); end
        if (last_xfer - first_xfer != 7) begin bad++; $display("FAIL stream_xfer_span got=%0d exp=7", last_xfer - first_xfer); end
        if (obs_words !== 4'd8) begin bad++; $display("FAIL stream_count got=%0d exp=8", obs_words); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_q.size() <= i || got_q[i] !== DATA_W'('h10 + i)) begin
                bad++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, (got_q.size() > i) ? got_q[i] : 'x, 'h10 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        preload(8, 'h10, 1'b0);
        clear_stats();
        bus.en = 1'b1; bus.out_ready = 1'b0;
        repeat (8) begin
            tick();
            total += 3;
            if (obs_read !== exp_read) begin bad++; $display("FAIL bp_read cyc=%0d got=%b exp=%b", cyc, obs_read, exp_read); end
            if (obs_valid !== exp_valid) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
            if (obs_busy !== exp_busy) begin bad++; $display("FAIL bp_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, exp_busy); end
            if (data_care) begin
                total++;
                if (obs_data !== exp_data) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, obs_data, exp_data); end
            end
        end
        total += 3;
        if (rd_cnt != 2) begin bad++; $display("FAIL bp_reads got=%0d exp=2", rd_cnt); end
        if (obs_data !== 8'h10) begin bad++; $display("FAIL bp_hold got=%h exp=10", obs_data); end
        if (obs_read !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b exp=0", obs_read); end
        bus.out_ready = 1'b1;
        repeat (14) begin
            tick();
            total += 2;
            if (obs_read !== exp_read) begin bad++; $display("FAIL bp2_read cyc=%0d got=%b exp=%b", cyc, obs_read, exp_read); end
            if (obs_valid !== exp_valid) begin bad++; $display("FAIL bp2_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_q.size() <= i || got_q[i] !== DATA_W'('h10 + i)) begin
                bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, (got_q.size() > i) ? got_q[i] : 'x, 'h10 + i);
            end
        end
    endtask

    task automatic test_en_drop();
        int busy_low = -1;
        apply_reset();
        preload(4, 'hA0, 1'b0);
        clear_stats();
        bus.en = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.en = 1'b0;
        repeat (6) begin
            tick();
            total += 3;
            if (obs_read !== exp_read) begin bad++; $display("FAIL endrop_read cyc=%0d got=%b exp=%b", cyc, obs_read, exp_read); end
            if (obs_valid !== exp_valid) begin bad++; $display("FAIL endrop_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
            if (obs_busy !== exp_busy) begin bad++; $display("FAIL endrop_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, exp_busy); end
            if (obs_busy === 1'b0 && busy_low < 0 && last_xfer >= 0) busy_low = cyc;
        end
        total += 3;
        if (rd_cnt != 1) begin bad++; $display("FAIL endrop_reads got=%0d exp=1", rd_cnt); end
        if (got_q.size() != 1 || got_q[0] !== 8'hA0) begin bad++; $display("FAIL endrop_word got_n=%0d exp_n=1 exp=a0", got_q.size()); end
        if (busy_low != last_xfer + 1) begin bad++; $display("FAIL endrop_busy_fall got=%0d exp=%0d", busy_low, last_xfer + 1); end
    endtask

    task automatic test_saturate();
        apply_reset();
        preload(20, 0, 1'b1);
        clear_stats();
        bus.en = 1'b1; bus.out_ready = 1'b1;
        repeat (26) begin
            tick();
            total += 2;
            if (obs_words !== exp_words) begin bad++; $display("FAIL sat_words cyc=%0d got=%0d exp=%0d", cyc, obs_words, exp_words); end
            if (data_care) begin
                if (obs_data !== exp_data) begin bad++; $display("FAIL sat_data cyc=%0d got=%h exp=%h", cyc, obs_data, exp_data); end
            end else if (obs_valid !== exp_valid) begin
                bad++; $display("FAIL sat_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid);
            end
        end
        total += 2;
        if (got_q.size() != 20) begin bad++; $display("FAIL sat_xfers got=%0d exp=20", got_q.size()); end
        if (obs_words !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", obs_words); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        preload(8, 'h30, 1'b0);
        bus.en = 1'b1; bus.out_ready = 1'b0;
        repeat (2) tick();
        total++;
        if (obs_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", obs_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_stats();
        bus.out_ready = 1'b1;
        tick();
        total += 2;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", obs_valid); end
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", obs_busy); end
        repeat (8) begin
            tick();
            total += 2;
            if (obs_valid !== exp_valid) begin bad++; $display("FAIL mid_valid2 cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
            if (obs_busy !== exp_busy) begin bad++; $display("FAIL mid_busy2 cyc=%0d got=%b exp=%b", cyc, obs_busy, exp_busy); end
        end
        total++;
        if (got_q.size() == 0 || got_q[0] !== 8'h32) begin bad++; $display("FAIL mid_next_word got_n=%0d exp=32", got_q.size()); end
    endtask

    task automatic test_random();
        apply_reset();
        up_q.delete();
        bus.fifo_empty = 1'b1;
        clear_stats();
        repeat (400) begin
            bus.en        = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) up_q.push_back(DATA_W'($urandom));
            bus.fifo_empty = (up_q.size() == 0);
            tick();
            total += 4;
            if (obs_read !== exp_read) begin bad++; $display("FAIL rnd_read cyc=%0d got=%b exp=%b", cyc, obs_read, exp_read); end
            if (obs_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, obs_valid, exp_valid); end
            if (obs_busy !== exp_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, exp_busy); end
            if (obs_words !== exp_words) begin bad++; $display("FAIL rnd_words cyc=%0d got=%0d exp=%0d", cyc, obs_words, exp_words); end
            if (data_care) begin
                total++;
                if (obs_data !== exp_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, obs_data, exp_data); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_data_out = '0; bus.out_ready = 1'b0;
        mpend = 1'b0; mpend_data = '0; mwords = 0; captured = 1'b0;
        clear_stats();
        test_reset();
        test_stream();
        test_backpressure();
        test_en_drop();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
